// File: rtl/hc_sync_fifo.sv
// Single-clock FIFO using all DEPTH entries, with programmable almost-full/empty
// thresholds, occupancy/free outputs, show-ahead or registered read, flush and sticky errors.
module hc_sync_fifo #(
  parameter int WIDTH     = 512,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  parameter int SHOWAHEAD = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           enq_data,
  input  logic                       enq_en,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       deq_en,
  output logic [WIDTH-1:0]           deq_data,
  output logic                       deq_valid,
  output logic                       empty,
  output logic                       almost_empty,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     free,
  input  logic                       err_clr,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             enq_acc, deq_acc;

  // Status is decoded from the registered count only, so it lags each edge by design.
  always_comb begin
    full         = (count_q == CW'(DEPTH));
    empty        = (count_q == '0);
    almost_full  = (count_q >= CW'(AF_THRESH));
    almost_empty = (count_q <= CW'(AE_THRESH));
    count        = count_q;
    free         = CW'(DEPTH) - count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

  assign enq_acc = enq_en & ~full  & ~flush;
  assign deq_acc = deq_en & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({enq_acc, deq_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // A set condition in the same cycle as err_clr takes precedence.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (enq_en & full  & ~flush) overflow_d  = 1'b1;
    if (deq_en & empty & ~flush) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_acc) mem_q[wr_ptr_q] <= enq_data;
  end

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      assign deq_data  = mem_q[rd_ptr_q];
      assign deq_valid = ~empty;
    end else begin : g_registered
      logic [WIDTH-1:0] rdata_q, rdata_d;
      logic             rvalid_q, rvalid_d;

      always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (deq_acc) begin
          rdata_d  = mem_q[rd_ptr_q];
          rvalid_d = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rdata_q  <= rdata_d;
          rvalid_q <= rvalid_d;
        end
      end

      assign deq_data  = rdata_q;
      assign deq_valid = rvalid_q;
    end
  endgenerate

endmodule

// File: tb/tb_hc_sync_fifo.sv
// Directed bench for hc_sync_fifo: a show-ahead and a registered-read instance
// share one stimulus stream and are checked against hand-computed values.
module tb_hc_sync_fifo;

  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] enq_data;
  logic         enq_en, deq_en, flush, err_clr;

  logic         sa_full, sa_af, sa_empty, sa_ae, sa_valid, sa_ovf, sa_udf;
  logic [W-1:0] sa_data;
  logic [3:0]   sa_count, sa_free;
  logic         rg_full, rg_af, rg_empty, rg_ae, rg_valid, rg_ovf, rg_udf;
  logic [W-1:0] rg_data;
  logic [3:0]   rg_count, rg_free;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hc_sync_fifo #(.WIDTH(W), .DEPTH(D), .SHOWAHEAD(1)) dut_sa (
    .clk(clk), .reset(reset), .enq_data(enq_data), .enq_en(enq_en),
    .full(sa_full), .almost_full(sa_af), .deq_en(deq_en), .deq_data(sa_data),
    .deq_valid(sa_valid), .empty(sa_empty), .almost_empty(sa_ae), .flush(flush),
    .count(sa_count), .free(sa_free), .err_clr(err_clr),
    .overflow(sa_ovf), .underflow(sa_udf)
  );

  hc_sync_fifo #(.WIDTH(W), .DEPTH(D), .SHOWAHEAD(0)) dut_rg (
    .clk(clk), .reset(reset), .enq_data(enq_data), .enq_en(enq_en),
    .full(rg_full), .almost_full(rg_af), .deq_en(deq_en), .deq_data(rg_data),
    .deq_valid(rg_valid), .empty(rg_empty), .almost_empty(rg_ae), .flush(flush),
    .count(rg_count), .free(rg_free), .err_clr(err_clr),
    .overflow(rg_ovf), .underflow(rg_udf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_en = 0; deq_en = 0; flush = 0; err_clr = 0;
  endtask

  task automatic push(input logic [W-1:0] v);
    enq_data = v; enq_en = 1;
    tick();
    enq_en = 0;
  endtask

  task automatic test_reset();
    idle(); enq_data = '0; reset = 1;
    #12 reset = 0;
    tick();
    n_checks++; if (sa_empty !== 1'b1 || sa_full !== 1'b0) begin n_fail++; $display("FAIL reset_empty_full: got %b/%b expected 1/0", sa_empty, sa_full); end
    n_checks++; if (sa_count !== 4'd0 || sa_free !== 4'd8) begin n_fail++; $display("FAIL reset_count_free: got %0d/%0d expected 0/8", sa_count, sa_free); end
    n_checks++; if (sa_ae !== 1'b1 || sa_af !== 1'b0) begin n_fail++; $display("FAIL reset_ae_af: got %b/%b expected 1/0", sa_ae, sa_af); end
    n_checks++; if (sa_ovf !== 1'b0 || sa_udf !== 1'b0) begin n_fail++; $display("FAIL reset_errors: got %b/%b expected 0/0", sa_ovf, sa_udf); end
    n_checks++; if (rg_valid !== 1'b0 || rg_data !== 8'h00 || sa_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got rg %b/%h sa %b expected 0/00 0", rg_valid, rg_data, sa_valid); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
      n_checks++; if (sa_count !== 4'(i) || sa_free !== 4'(8 - i)) begin n_fail++; $display("FAIL fill_count_%0d: got %0d/%0d expected %0d/%0d", i, sa_count, sa_free, i, 8 - i); end
      n_checks++; if (sa_full !== (i == 8) || sa_af !== (i >= 6) || sa_ae !== (i <= 1)) begin n_fail++; $display("FAIL fill_flags_%0d: got full %b af %b ae %b", i, sa_full, sa_af, sa_ae); end
    end
    push(8'd99);
    n_checks++; if (sa_ovf !== 1'b1 || sa_count !== 4'd8) begin n_fail++; $display("FAIL fill_overflow: got ovf %b count %0d expected 1/8", sa_ovf, sa_count); end
    n_checks++; if (sa_data !== 8'd1) begin n_fail++; $display("FAIL fill_head: got %0d expected 1", sa_data); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      n_checks++; if (sa_data !== 8'(i) || sa_valid !== 1'b1) begin n_fail++; $display("FAIL drain_sa_%0d: got %0d/%b expected %0d/1", i, sa_data, sa_valid, i); end
      deq_en = 1; tick(); deq_en = 0;
      n_checks++; if (sa_count !== 4'(8 - i) || sa_empty !== (i == 8) || sa_ae !== (i >= 7)) begin n_fail++; $display("FAIL drain_status_%0d: got count %0d empty %b ae %b", i, sa_count, sa_empty, sa_ae); end
      n_checks++; if (rg_valid !== 1'b1 || rg_data !== 8'(i)) begin n_fail++; $display("FAIL drain_rg_%0d: got %b/%0d expected 1/%0d", i, rg_valid, rg_data, i); end
    end
    deq_en = 1; tick(); deq_en = 0;
    n_checks++; if (sa_udf !== 1'b1 || sa_count !== 4'd0 || rg_valid !== 1'b0) begin n_fail++; $display("FAIL drain_underflow: got udf %b count %0d rvalid %b expected 1/0/0", sa_udf, sa_count, rg_valid); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) push(8'(100 + i));
    for (int i = 0; i < 20; i++) begin
      n_checks++; if (sa_data !== 8'(100 + i)) begin n_fail++; $display("FAIL wrap_data_%0d: got %0d expected %0d", i, sa_data, 100 + i); end
      enq_data = 8'(103 + i); enq_en = 1; deq_en = 1;
      tick(); idle();
      n_checks++; if (sa_count !== 4'd3) begin n_fail++; $display("FAIL wrap_count_%0d: got %0d expected 3", i, sa_count); end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (sa_data !== 8'(120 + i)) begin n_fail++; $display("FAIL wrap_tail_%0d: got %0d expected %0d", i, sa_data, 120 + i); end
      deq_en = 1; tick(); deq_en = 0;
    end
    n_checks++; if (sa_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b expected 1", sa_empty); end
  endtask

  task automatic test_simul_full();
    err_clr = 1; tick(); err_clr = 0;
    n_checks++; if (sa_ovf !== 1'b0 || sa_udf !== 1'b0) begin n_fail++; $display("FAIL errclr_pre_full: got %b/%b expected 0/0", sa_ovf, sa_udf); end
    for (int i = 0; i < 8; i++) push(8'(10 + i));
    enq_data = 8'hEE; enq_en = 1; deq_en = 1;
    tick(); idle();
    n_checks++; if (sa_count !== 4'd7 || sa_ovf !== 1'b1 || sa_udf !== 1'b0) begin n_fail++; $display("FAIL simul_full: got count %0d ovf %b udf %b expected 7/1/0", sa_count, sa_ovf, sa_udf); end
    for (int i = 0; i < 7; i++) begin
      n_checks++; if (sa_data !== 8'(11 + i)) begin n_fail++; $display("FAIL simul_full_drain_%0d: got %h expected %h", i, sa_data, 8'(11 + i)); end
      deq_en = 1; tick(); deq_en = 0;
    end
  endtask

  task automatic test_simul_empty();
    err_clr = 1; tick(); err_clr = 0;
    enq_data = 8'h3C; enq_en = 1; deq_en = 1;
    tick(); idle();
    n_checks++; if (sa_count !== 4'd1 || sa_udf !== 1'b1 || sa_ovf !== 1'b0) begin n_fail++; $display("FAIL simul_empty: got count %0d udf %b ovf %b expected 1/1/0", sa_count, sa_udf, sa_ovf); end
    n_checks++; if (sa_data !== 8'h3C || sa_valid !== 1'b1 || rg_valid !== 1'b0) begin n_fail++; $display("FAIL simul_empty_data: got %h/%b rvalid %b expected 3c/1/0", sa_data, sa_valid, rg_valid); end
    deq_en = 1; tick(); deq_en = 0;
    n_checks++; if (rg_valid !== 1'b1 || rg_data !== 8'h3C || sa_count !== 4'd0) begin n_fail++; $display("FAIL simul_empty_rd: got %b/%h count %0d expected 1/3c/0", rg_valid, rg_data, sa_count); end
    err_clr = 1; deq_en = 1; tick(); idle();
    n_checks++; if (sa_udf !== 1'b1) begin n_fail++; $display("FAIL set_wins: got udf %b expected 1", sa_udf); end
  endtask

  task automatic test_registered();
    push(8'hA5);
    deq_en = 1; tick(); deq_en = 0;
    n_checks++; if (rg_valid !== 1'b1 || rg_data !== 8'hA5) begin n_fail++; $display("FAIL reg_read: got %b/%h expected 1/a5", rg_valid, rg_data); end
    tick();
    n_checks++; if (rg_valid !== 1'b0 || rg_data !== 8'hA5) begin n_fail++; $display("FAIL reg_hold: got %b/%h expected 0/a5", rg_valid, rg_data); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) push(8'(50 + i));
    n_checks++; if (sa_count !== 4'd5) begin n_fail++; $display("FAIL flush_pre: got %0d expected 5", sa_count); end
    enq_data = 8'hBB; flush = 1; enq_en = 1; deq_en = 1;
    tick(); idle();
    n_checks++; if (sa_count !== 4'd0 || sa_empty !== 1'b1 || sa_free !== 4'd8) begin n_fail++; $display("FAIL flush_count: got %0d empty %b free %0d expected 0/1/8", sa_count, sa_empty, sa_free); end
    n_checks++; if (sa_ovf !== 1'b0 || sa_udf !== 1'b1) begin n_fail++; $display("FAIL flush_errors: got %b/%b expected 0/1", sa_ovf, sa_udf); end
    n_checks++; if (rg_valid !== 1'b0 || rg_data !== 8'hA5) begin n_fail++; $display("FAIL flush_rg: got %b/%h expected 0/a5", rg_valid, rg_data); end
    push(8'h77);
    n_checks++; if (sa_data !== 8'h77 || sa_count !== 4'd1) begin n_fail++; $display("FAIL flush_after: got %h/%0d expected 77/1", sa_data, sa_count); end
  endtask

  task automatic test_async_reset();
    push(8'h78);
    #3 reset = 1;
    #1;
    n_checks++; if (sa_count !== 4'd0 || sa_empty !== 1'b1 || sa_udf !== 1'b0 || sa_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset: got count %0d empty %b udf %b valid %b expected 0/1/0/0", sa_count, sa_empty, sa_udf, sa_valid); end
    n_checks++; if (rg_data !== 8'h00 || rg_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_rg: got %h/%b expected 00/0", rg_data, rg_valid); end
    #2 reset = 0;
    tick();
  endtask

  task automatic test_err_clr();
    deq_en = 1; tick(); deq_en = 0;
    for (int i = 0; i < 9; i++) push(8'(i));
    n_checks++; if (sa_ovf !== 1'b1 || sa_udf !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b/%b expected 1/1", sa_ovf, sa_udf); end
    err_clr = 1; tick(); err_clr = 0;
    n_checks++; if (sa_ovf !== 1'b0 || sa_udf !== 1'b0 || sa_count !== 4'd8) begin n_fail++; $display("FAIL err_clr: got %b/%b count %0d expected 0/0/8", sa_ovf, sa_udf, sa_count); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simul_full();
    test_simul_empty();
    test_registered();
    test_flush();
    test_async_reset();
    test_err_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
